// File: rtl/fp_norm_sequencer_if.sv
// Handshake bus for fp_norm_sequencer: request side (in_*) and result side (out_*).
interface fp_norm_sequencer_if #(
   parameter int M = 23,
   parameter int E = 8
);
   localparam int SW = $clog2(M+1);

   logic          in_valid;
   logic          in_ready;
   logic          in_carry;
   logic [M:0]    in_sig;
   logic [E-1:0]  in_exp;
   logic          out_valid;
   logic          out_ready;
   logic [M-1:0]  out_frac;
   logic [E-1:0]  out_exp;
   logic [SW-1:0] out_shamt;
   logic          out_overflow;
   logic          out_denorm;

   modport master (
      output in_valid, in_carry, in_sig, in_exp, out_ready,
      input  in_ready, out_valid, out_frac, out_exp, out_shamt, out_overflow, out_denorm
   );

   modport slave (
      input  in_valid, in_carry, in_sig, in_exp, out_ready,
      output in_ready, out_valid, out_frac, out_exp, out_shamt, out_overflow, out_denorm
   );
endinterface

// File: rtl/fp_norm_sequencer.sv
// Iterative FP normalizer: one left-shift step per clock, result held in DONE
// until the consumer takes it.
module fp_norm_sequencer #(
   parameter int M = 23,
   parameter int E = 8
) (
   input  logic               clk,
   input  logic               rst,
   fp_norm_sequencer_if.slave bus
);
   localparam int SW = $clog2(M+1);
   localparam logic [E-1:0]  EMAX = '1;
   localparam logic [E-1:0]  EOVF = {{(E-1){1'b1}}, 1'b0};
   localparam logic [E-1:0]  EONE = {{(E-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] CONE = {{(SW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t        state_q;
   logic          c_q;
   logic [M:0]    s_q;
   logic [E-1:0]  e_q;
   logic [SW-1:0] cnt_q;
   logic [M-1:0]  frac_q;
   logic [E-1:0]  exp_q;
   logic [SW-1:0] shamt_q;
   logic          ovf_q;
   logic          den_q;
   logic          valid_q;

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.out_valid    = valid_q;
   assign bus.out_frac     = frac_q;
   assign bus.out_exp      = exp_q;
   assign bus.out_shamt    = shamt_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_denorm   = den_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= 1'b0;
         s_q     <= '0;
         e_q     <= '0;
         cnt_q   <= '0;
         frac_q  <= '0;
         exp_q   <= '0;
         shamt_q <= '0;
         ovf_q   <= 1'b0;
         den_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  c_q     <= bus.in_carry;
                  s_q     <= bus.in_sig;
                  e_q     <= bus.in_exp;
                  cnt_q   <= '0;
                  state_q <= NORM;
               end
            end
            NORM: begin
               // Rules 1-3 can only hit on the first NORM cycle: left shifts never raise e.
               if (e_q == EMAX) begin
                  exp_q <= EMAX; frac_q <= s_q[M-1:0]; shamt_q <= '0;
                  ovf_q <= 1'b0; den_q <= 1'b0;
                  valid_q <= 1'b1; state_q <= DONE;
               end else if (c_q && e_q == EOVF) begin
                  exp_q <= EMAX; frac_q <= '0; shamt_q <= '0;
                  ovf_q <= 1'b1; den_q <= 1'b0;
                  valid_q <= 1'b1; state_q <= DONE;
               end else if (c_q) begin
                  // {1, s[M:1]} with the hidden bit dropped leaves s[M:1].
                  exp_q <= e_q + EONE; frac_q <= s_q[M:1]; shamt_q <= '0;
                  ovf_q <= 1'b0; den_q <= 1'b0;
                  valid_q <= 1'b1; state_q <= DONE;
               end else if (s_q == '0) begin
                  exp_q <= '0; frac_q <= '0; shamt_q <= cnt_q;
                  ovf_q <= 1'b0; den_q <= 1'b0;
                  valid_q <= 1'b1; state_q <= DONE;
               end else if (s_q[M]) begin
                  exp_q <= (e_q == '0) ? EONE : e_q; frac_q <= s_q[M-1:0]; shamt_q <= cnt_q;
                  ovf_q <= 1'b0; den_q <= 1'b0;
                  valid_q <= 1'b1; state_q <= DONE;
               end else if (e_q <= EONE) begin
                  // Exponent 0 and 1 share a scale, so no shift is needed here.
                  exp_q <= '0; frac_q <= s_q[M-1:0]; shamt_q <= cnt_q;
                  ovf_q <= 1'b0; den_q <= 1'b1;
                  valid_q <= 1'b1; state_q <= DONE;
               end else begin
                  s_q   <= s_q << 1;
                  e_q   <= e_q - EONE;
                  cnt_q <= cnt_q + CONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed scoreboard bench for fp_norm_sequencer (M=23, E=8).
module tb_fp_norm_sequencer;
   localparam int M  = 23;
   localparam int E  = 8;
   localparam int SW = $clog2(M+1);

   typedef struct {
      logic [M-1:0]  frac;
      logic [E-1:0]  expo;
      logic [SW-1:0] shamt;
      logic          ovf;
      logic          den;
      int            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   fp_norm_sequencer_if #(.M(M), .E(E)) bus ();
   fp_norm_sequencer #(.M(M), .E(E)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 0);
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, ".frac"}, 32'(bus.out_frac), 0);
      chk({tag, ".exp"}, 32'(bus.out_exp), 0);
      chk({tag, ".shamt"}, 32'(bus.out_shamt), 0);
      chk({tag, ".ovf"}, 32'(bus.out_overflow), 0);
      chk({tag, ".den"}, 32'(bus.out_denorm), 0);
   endtask

   // Drive one request, push its expectation, wait (bounded) for the result,
   // pop and compare, optionally stall the consumer, then accept.
   task automatic run(input string tag, input logic carry, input logic [M:0] sig,
                      input logic [E-1:0] ex, input exp_t e, input int stall);
      exp_t got;
      int   lat;
      logic [M-1:0] f0;
      logic [E-1:0] x0;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1; bus.in_carry = carry; bus.in_sig = sig; bus.in_exp = ex;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      got = sb.pop_front();
      chk({tag, ".latency"}, 32'(lat), 32'(got.lat));
      chk({tag, ".frac"}, 32'(bus.out_frac), 32'(got.frac));
      chk({tag, ".exp"}, 32'(bus.out_exp), 32'(got.expo));
      chk({tag, ".shamt"}, 32'(bus.out_shamt), 32'(got.shamt));
      chk({tag, ".ovf"}, 32'(bus.out_overflow), 32'(got.ovf));
      chk({tag, ".den"}, 32'(bus.out_denorm), 32'(got.den));
      f0 = bus.out_frac; x0 = bus.out_exp;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk({tag, ".hold_valid"}, 32'(bus.out_valid), 1);
         chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 0);
         chk({tag, ".hold_frac"}, 32'(bus.out_frac), 32'(f0));
         chk({tag, ".hold_exp"}, 32'(bus.out_exp), 32'(x0));
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, ".released"}, 32'(bus.out_valid), 0);
   endtask

   function automatic exp_t mk(input logic [M-1:0] f, input logic [E-1:0] x,
                               input logic [SW-1:0] sh, input logic o, input logic d, input int l);
      exp_t r;
      r.frac = f; r.expo = x; r.shamt = sh; r.ovf = o; r.den = d; r.lat = l;
      return r;
   endfunction

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_carry = 1'b0; bus.in_sig = '0; bus.in_exp = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_zero_outputs("reset");

      run("one_shift",  1'b0, 24'h400000, 8'h80, mk(23'h000000, 8'h7F, 5'd1,  1'b0, 1'b0, 2),  0);
      run("carry",      1'b1, 24'h800000, 8'h80, mk(23'h400000, 8'h81, 5'd0,  1'b0, 1'b0, 1),  0);
      run("carry_ovf",  1'b1, 24'h800000, 8'hFE, mk(23'h000000, 8'hFF, 5'd0,  1'b1, 1'b0, 1),  0);
      run("special",    1'b0, 24'h800001, 8'hFF, mk(23'h000001, 8'hFF, 5'd0,  1'b0, 1'b0, 1),  0);
      run("denorm",     1'b0, 24'h000001, 8'h05, mk(23'h000010, 8'h00, 5'd4,  1'b0, 1'b1, 5),  0);
      run("denorm_imm", 1'b0, 24'h000100, 8'h01, mk(23'h000100, 8'h00, 5'd0,  1'b0, 1'b1, 1),  0);
      run("norm_e0",    1'b0, 24'h800005, 8'h00, mk(23'h000005, 8'h01, 5'd0,  1'b0, 1'b0, 1),  0);
      run("zero",       1'b0, 24'h000000, 8'h40, mk(23'h000000, 8'h00, 5'd0,  1'b0, 1'b0, 1),  0);
      run("worst",      1'b0, 24'h000001, 8'h80, mk(23'h000000, 8'h69, 5'd23, 1'b0, 1'b0, 24), 5);

      // Abort a long normalization part-way; stale outputs from "worst" must clear.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_carry = 1'b0; bus.in_sig = 24'h000001; bus.in_exp = 8'h80;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_zero_outputs("rst_mid_norm");

      run("after_rst",  1'b0, 24'h400000, 8'h80, mk(23'h000000, 8'h7F, 5'd1,  1'b0, 1'b0, 2),  0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_norm_sequencer.md
# fp_norm_sequencer

Multi-cycle normalizer for the GPU floating-point datapath: takes a raw adder/multiplier result (carry bit, explicit-hidden-bit significand, biased exponent) and produces a normalized or denormalized `{exp, frac}` pair. It performs one shift step per clock instead of an M-deep combinational shift chain. Shift count and flags are exposed for pipeline bookkeeping. Valid/ready handshakes on both sides let it sit between the FP arithmetic stage and the result writeback.

## Interface
- `M`, 23, fraction width; the significand is M+1 bits with an explicit hidden bit at `[M]`.
- `E`, 8, exponent width; all-ones is the Inf/NaN encoding, zero is the denormal encoding.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `in_carry`  in  1  mantissa overflow (bit above the hidden bit).
- `in_sig`  in  M+1  significand `{hidden, frac}`.
- `in_exp`  in  E  biased exponent.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts.
- `out_frac`  out  M  normalized fraction (hidden bit dropped).
- `out_exp`  out  E  result exponent.
- `out_shamt`  out  $clog2(M+1)  number of left shifts performed.
- `out_overflow`  out  1  exponent overflow to infinity.
- `out_denorm`  out  1  result is denormal (`out_exp==0`, `out_frac!=0`).

## Operation
- FSM states: IDLE, NORM, DONE. Reset puts the FSM in IDLE and clears all outputs and internal registers to 0.
- **IDLE:** if `in_valid`, latch `in_carry`, `in_sig` and `in_exp` into `c`, `s` and `e`, clear the shift counter, and go to NORM.
- **NORM:** each cycle, exactly one of the rules below fires, checked in priority order. A finalizing rule writes the output registers and moves the FSM to DONE.
  1. `e=='1`: pass through. Result `exp='1`, `frac=s[M-1:0]`, flags 0.
  2. `c==1` and `e=='1-1`: overflow. Result `exp='1`, `frac=0`, `out_overflow=1`.
  3. `c==1`: right shift. `s={1'b1,s[M:1]}`, `exp=e+1`, `frac=s[M-1:0]` of the shifted value, shamt 0.
  4. `s==0`: zero. Result `exp=0`, `frac=0`.
  5. `s[M]==1`: already normalized. Result `exp=(e==0)?1:e`, `frac=s[M-1:0]`.
  6. `e<=1`: underflow to denormal. Result `exp=0`, `frac=s[M-1:0]`, `out_denorm=1`.
  7. Otherwise, left shift (non-final): `s=s<<1`, `e=e-1`, shamt+1; stay in NORM.
- Rule 6 does not shift, because encoding 0 has the same scale as exponent 1.
- Left shifts only decrement `e`, so rules 1–3 can only fire on the first NORM cycle.
- `out_shamt` ≤ M always; the counter never wraps.
- **DONE:** `out_valid=1`, outputs held stable. When `out_ready` is high, go to IDLE and deassert `out_valid`.
- `in_ready` is low in NORM and DONE. New input is not accepted in the DONE→IDLE cycle.
- Unsigned exponent arithmetic, E bits; no path produces exponent wrap.
- Asserting `rst` in any state aborts the operation: next cycle the FSM is in IDLE, `out_valid=0`, and all outputs are 0.

## Timing
- Acceptance happens at edge T0 (`in_valid && in_ready`).
- With k left shifts, the result registers load at edge T0+k+1, and `out_valid` is high from that edge on.
- Latency is k+1 clocks; it is 1 clock for special, carry, zero, already-normalized and immediate-denormal cases. Worst case is M+1 clocks (only `s[0]` set, large `e`).
- Minimum initiation interval is k+3 clocks with `out_ready` tied high.
- `out_*` data changes only on the edge entering DONE or on reset.

## Test plan
M=23, E=8 throughout.
- **One left shift:** sig=0x400000, exp=0x80, carry=0 -> exp=0x7F, frac=0x000000, shamt=1; `out_valid` 2 clocks after acceptance.
- **Carry:** carry=1, sig=0x800000, exp=0x80 -> exp=0x81, frac=0x400000, shamt=0, latency 1.
- **Carry overflow:** carry=1, exp=0xFE -> exp=0xFF, frac=0, `out_overflow=1`.
- **Special passthrough:** exp=0xFF, sig=0x800001 -> exp=0xFF, frac=0x000001, flags 0.
- **Denormal:** sig=0x000001, exp=0x05 -> 4 shifts then rule 6: exp=0x00, frac=0x000010, `out_denorm=1`, shamt=4, latency 5.
- **Worst case, zero, backpressure, reset:**
  - sig=0x000001, exp=0x80 -> shamt=23, exp=0x69, frac=0, latency 24.
  - sig=0 -> exp=0, frac=0, latency 1.
  - Hold `out_ready` low 5 clocks -> outputs stable and `in_ready` low.
  - `rst` pulse mid-NORM -> IDLE, all outputs 0.
